adc_arbiter: RTL and testbench
==============================

ADC_ARBITER -- requirements
Module: adc_arbiter

Interface
REQ-001 SHALL have port: adc_clk  input  1  ADC serial clock (3.125 MHz); all state updates on its rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: req  input  3  per-requester conversion request, level, bit i = requester i.
REQ-004 SHALL have ports: ch0, ch1, ch2  input  3 each  channel address for requester 0/1/2, sampled at grant.
REQ-005 SHALL have port: gnt  output  3  one-hot grant, held for the whole transaction.
REQ-006 SHALL have port: result  output  12  last conversion value.
REQ-007 SHALL have port: result_valid  output  3  one-hot, one-cycle pulse to the granted requester.
REQ-008 SHALL have port: busy  output  1  high in any state except IDLE.
REQ-009 SHALL have ports: adc_cs_n  output  1; din  output  1; dout  input  1  ADC128S022 serial interface.

Function
REQ-010 SHALL implement states IDLE, PRIME, GAP, CONVERT, DONE, with a 4-bit frame counter k = 0..15 in PRIME/CONVERT.
REQ-011 IDLE: if req != 0 at edge T, SHALL grant round-robin starting at (last_grant+1) mod 3, latch that requester's channel, and assert gnt from T.
REQ-012 From IDLE, SHALL enter PRIME when priming is required (REQ-024), else CONVERT, with k = 0 and adc_cs_n = 0 from T.
REQ-013 In PRIME/CONVERT, din SHALL equal channel[2], [1], [0] in frame cycles k = 2, 3, 4; 0 in all other cycles; registered output.
REQ-014 In CONVERT, dout SHALL be shifted in MSB-first at the rising edges ending frame cycles k = 4..15, giving 12 bits.
REQ-015 PRIME k = 15 -> GAP: adc_cs_n = 1 for exactly one cycle, dout ignored -> CONVERT with k = 0.
REQ-016 CONVERT k = 15 -> DONE at edge T+16 (no prime): result <= shifted value, result_valid[grantee] = 1, adc_cs_n = 1.
REQ-017 DONE -> IDLE after one cycle: result_valid = 0, gnt = 0, last_grant updated; result holds its value.
REQ-018 Back-to-back: a request sampled in IDLE at T+17 SHALL start the next frame at T+17; minimum cs_n high time is 1 cycle (DONE).
REQ-019 Latency: grant edge to result_valid SHALL be 16 cycles without priming and 33 cycles with priming.
REQ-020 A deasserted req mid-transaction SHALL NOT abort it; the frame completes and result_valid still pulses.
REQ-021 Changes to chX after grant SHALL be ignored until the next grant.
REQ-022 SHALL track last_ch (the address last sent to the ADC) and addr_known, updated at the end of every PRIME/CONVERT frame.

Reset
REQ-023 While rst = 1 at an edge, SHALL set: state IDLE, adc_cs_n = 1, din = 0, gnt = 0, result = 0, result_valid = 0, busy = 0, k = 0, last_grant = 2 (requester 0 is served first), addr_known = 0; reset mid-frame SHALL abort the frame with no result_valid.

Configuration
REQ-024 With ADC_ARB_PRIME_EN defined: priming SHALL be required when addr_known = 0 or channel != last_ch.
REQ-025 With ADC_ARB_PRIME_EN undefined: PRIME/GAP SHALL be omitted and every grant SHALL go directly to CONVERT; result then reflects the previously addressed channel (legacy single-frame behaviour), latency 16.

Verification
REQ-026 With PRIME_EN, after reset, req = 001, ch0 = 3, dout model returns 0xA5C for ch3 -> gnt = 001, din pattern 011 at k = 2..4 in both frames, result_valid = 001 at grant+33, result = 0xA5C.
REQ-027 Repeat ch0 = 3 immediately -> no PRIME, result_valid at grant+16, adc_cs_n high for exactly 1 cycle between frames.
REQ-028 req = 111 held -> grants 001, 010, 100, 001 in order, one result_valid pulse per grant, never two grant bits set at once.
REQ-029 rst pulsed at frame cycle k = 8 -> adc_cs_n = 1 next cycle, no result_valid, next grant goes to requester 0 and primes.
REQ-030 With PRIME_EN undefined, req = 010, ch1 = 6 -> single frame, result_valid = 010 at grant+16, din 110 at k = 2..4.

Source files
------------

// File: rtl/adc_arbiter.sv
// Round-robin arbiter sharing one ADC128S022 between three requesters.
// Define ADC_ARB_PRIME_EN to add a priming frame whenever the addressed channel changes.
module adc_arbiter (
  input  logic        adc_clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [2:0]  ch0,
  input  logic [2:0]  ch1,
  input  logic [2:0]  ch2,
  output logic [2:0]  gnt,
  output logic [11:0] result,
  output logic [2:0]  result_valid,
  output logic        busy,
  output logic        adc_cs_n,
  output logic        din,
  input  logic        dout
);

  typedef enum logic [2:0] {IDLE, PRIME, GAP, CONVERT, DONE} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  k_reg, k_next;
  logic [2:0]  chan_reg, chan_next;
  logic [10:0] shift_reg, shift_next;
  logic [2:0]  gnt_reg, gnt_next;
  logic [1:0]  gidx_reg, gidx_next;
  logic [1:0]  last_grant_reg, last_grant_next;
  logic [11:0] result_reg, result_next;
  logic [2:0]  rv_reg, rv_next;
  logic        cs_n_reg, cs_n_next;
  logic        din_reg, din_next;
  logic [2:0]  last_ch_reg, last_ch_next;
  logic        addr_known_reg, addr_known_next;

  function automatic logic [1:0] wrap3(input logic [1:0] a, input logic [1:0] b);
    logic [2:0] s;
    logic [2:0] t;
    s = {1'b0, a} + {1'b0, b};
    t = s - 3'd3;
    return (s >= 3'd3) ? t[1:0] : s[1:0];
  endfunction

  // In DONE the grantee just served is the round-robin reference, so a
  // back-to-back grant already rotates past it.
  logic [1:0] arb_last;
  logic [1:0] cand_idx [3];
  logic [2:0] cand_req;
  logic       pick_valid;
  logic [1:0] pick_idx;
  logic [2:0] pick_ch;
  logic       need_prime;

  assign arb_last = (state_reg == DONE) ? gidx_reg : last_grant_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_cand
      assign cand_idx[gi] = wrap3(arb_last, 2'(gi + 1));
      assign cand_req[gi] = req[cand_idx[gi]];
    end
  endgenerate

  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = 2'd0;
    for (int i = 2; i >= 0; i--) begin
      if (cand_req[i]) begin
        pick_valid = 1'b1;
        pick_idx   = cand_idx[i];
      end
    end
  end

  always_comb begin
    case (pick_idx)
      2'd0:    pick_ch = ch0;
      2'd1:    pick_ch = ch1;
      default: pick_ch = ch2;
    endcase
  end

`ifdef ADC_ARB_PRIME_EN
  assign need_prime = !addr_known_reg || (pick_ch != last_ch_reg);
`else
  logic unused_track;
  assign need_prime   = 1'b0;
  assign unused_track = ^{last_ch_reg, addr_known_reg};
`endif

  always_comb begin
    state_next      = state_reg;
    k_next          = k_reg;
    chan_next       = chan_reg;
    shift_next      = shift_reg;
    gnt_next        = gnt_reg;
    gidx_next       = gidx_reg;
    last_grant_next = last_grant_reg;
    result_next     = result_reg;
    rv_next         = 3'b000;
    cs_n_next       = cs_n_reg;
    din_next        = 1'b0;
    last_ch_next    = last_ch_reg;
    addr_known_next = addr_known_reg;

    case (state_reg)
      IDLE, DONE: begin
        if (state_reg == DONE) begin
          gnt_next        = 3'b000;
          last_grant_next = gidx_reg;
          cs_n_next       = 1'b1;
          state_next      = IDLE;
        end
        if (pick_valid) begin
          gnt_next   = 3'b001 << pick_idx;
          gidx_next  = pick_idx;
          chan_next  = pick_ch;
          k_next     = 4'd0;
          cs_n_next  = 1'b0;
          state_next = need_prime ? PRIME : CONVERT;
        end
      end

      PRIME, CONVERT: begin
        k_next = k_reg + 4'd1;
        // din is registered, so each address bit is loaded one cycle early
        case (k_reg)
          4'd1:    din_next = chan_reg[2];
          4'd2:    din_next = chan_reg[1];
          4'd3:    din_next = chan_reg[0];
          default: din_next = 1'b0;
        endcase
        if (state_reg == CONVERT && k_reg >= 4'd4)
          shift_next = {shift_reg[9:0], dout};
        if (k_reg == 4'd15) begin
          k_next          = 4'd0;
          cs_n_next       = 1'b1;
          last_ch_next    = chan_reg;
          addr_known_next = 1'b1;
          if (state_reg == PRIME) begin
            state_next = GAP;
          end else begin
            state_next  = DONE;
            result_next = {shift_reg, dout};
            rv_next     = gnt_reg;
          end
        end
      end

      GAP: begin
        state_next = CONVERT;
        k_next     = 4'd0;
        cs_n_next  = 1'b0;
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      k_reg          <= 4'd0;
      chan_reg       <= 3'd0;
      shift_reg      <= 11'd0;
      gnt_reg        <= 3'b000;
      gidx_reg       <= 2'd0;
      last_grant_reg <= 2'd2;
      result_reg     <= 12'd0;
      rv_reg         <= 3'b000;
      cs_n_reg       <= 1'b1;
      din_reg        <= 1'b0;
      last_ch_reg    <= 3'd0;
      addr_known_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      k_reg          <= k_next;
      chan_reg       <= chan_next;
      shift_reg      <= shift_next;
      gnt_reg        <= gnt_next;
      gidx_reg       <= gidx_next;
      last_grant_reg <= last_grant_next;
      result_reg     <= result_next;
      rv_reg         <= rv_next;
      cs_n_reg       <= cs_n_next;
      din_reg        <= din_next;
      last_ch_reg    <= last_ch_next;
      addr_known_reg <= addr_known_next;
    end
  end

  assign gnt          = gnt_reg;
  assign result       = result_reg;
  assign result_valid = rv_reg;
  assign busy         = (state_reg != IDLE);
  assign adc_cs_n     = cs_n_reg;
  assign din          = din_reg;

endmodule

// File: tb/tb_adc_arbiter.sv
// Directed bench for adc_arbiter with a behavioural ADC128S022 model.
module tb_adc_arbiter;

`ifdef ADC_ARB_PRIME_EN
  localparam bit PRIME = 1'b1;
`else
  localparam bit PRIME = 1'b0;
`endif

  logic        adc_clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [2:0]  ch0 = 3'd0, ch1 = 3'd0, ch2 = 3'd0;
  logic [2:0]  gnt;
  logic [11:0] result;
  logic [2:0]  result_valid;
  logic        busy;
  logic        adc_cs_n;
  logic        din;
  logic        dout = 1'b0;

  adc_arbiter dut (
    .adc_clk(adc_clk), .rst(rst), .req(req),
    .ch0(ch0), .ch1(ch1), .ch2(ch2),
    .gnt(gnt), .result(result), .result_valid(result_valid), .busy(busy),
    .adc_cs_n(adc_cs_n), .din(din), .dout(dout)
  );

  always #160 adc_clk = ~adc_clk;

  int vectors = 0;
  int miscompares = 0;
  logic [11:0] vals [8];

  // ADC model: address bits read in frame cycles 2..4, data for the
  // previously addressed channel driven MSB-first in cycles 4..15.
  int         cnt = 0;
  logic [2:0] cur_addr = 3'd0;
  logic [2:0] prev_addr = 3'd0;
  logic [2:0] frame_q [$];
  int         onehot_bad = 0;
  int         din_bad = 0;

  always @(negedge adc_clk) begin
    logic [11:0] v;
    if ($countones(gnt) > 1) onehot_bad++;
    if (adc_cs_n === 1'b0) begin
      if (cnt == 2) cur_addr[2] = din;
      if (cnt == 3) cur_addr[1] = din;
      if (cnt == 4) cur_addr[0] = din;
      if (din !== 1'b0 && (cnt < 2 || cnt > 4)) din_bad++;
      v = vals[prev_addr];
      dout = (cnt >= 4 && cnt <= 15) ? v[15 - cnt] : 1'b0;
      cnt++;
    end else begin
      if (!rst && din !== 1'b0) din_bad++;
      if (cnt == 16) begin
        prev_addr = cur_addr;
        frame_q.push_back(cur_addr);
      end
      cnt  = 0;
      dout = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic txn(input string tag, input logic [2:0] exp_gnt, input int exp_lat,
                     input logic [11:0] exp_res, input int exp_wait,
                     input logic [2:0] req_mid, input bit scramble,
                     input int exp_frames, input logic [2:0] exp_addr);
    int w = 0;
    int lat = 0;
    int held_bad = 0;
    do begin
      @(posedge adc_clk); #1; w++;
    end while (adc_cs_n !== 1'b0 && w < 50);
    chk({tag, " grant"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, " busy"}, 32'(busy), 32'd1);
    if (exp_wait > 0) chk({tag, " cs_n_high_cycles"}, 32'(w), 32'(exp_wait));
    req = req_mid;
    if (scramble) begin ch0 = 3'd7; ch1 = 3'd7; ch2 = 3'd7; end
    do begin
      @(posedge adc_clk); #1; lat++;
      if (gnt !== exp_gnt) held_bad++;
    end while (result_valid === 3'b000 && lat < 60);
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " result_valid"}, 32'(result_valid), 32'(exp_gnt));
    chk({tag, " result"}, 32'(result), 32'(exp_res));
    chk({tag, " gnt_held"}, 32'(held_bad), 32'd0);
    @(negedge adc_clk); #1;
    chk({tag, " frames"}, 32'(frame_q.size()), 32'(exp_frames));
    while (frame_q.size() > 0) chk({tag, " din_addr"}, 32'(frame_q.pop_front()), 32'(exp_addr));
    $display("%s: gnt=%b lat=%0d result=%h", tag, exp_gnt, lat, result);
  endtask

  initial begin
    int w;
    int rv_seen;
    vals[0] = 12'h123; vals[1] = 12'h4D2; vals[2] = 12'h7E1; vals[3] = 12'hA5C;
    vals[4] = 12'h0F0; vals[5] = 12'hB3A; vals[6] = 12'h3C9; vals[7] = 12'hFFF;

    repeat (3) @(posedge adc_clk);
    #1;
    chk("reset gnt", 32'(gnt), 32'd0);
    chk("reset cs_n", 32'(adc_cs_n), 32'd1);
    chk("reset din", 32'(din), 32'd0);
    chk("reset result", 32'(result), 32'd0);
    chk("reset result_valid", 32'(result_valid), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    $display("reset: checked idle outputs");

    rst = 1'b0;
    ch0 = 3'd3; ch1 = 3'd6; ch2 = 3'd5;
    req = 3'b001;
    txn("t1 ch0=3", 3'b001, PRIME ? 33 : 16, PRIME ? vals[3] : vals[0], 0,
        3'b001, 1'b0, PRIME ? 2 : 1, 3'd3);
    txn("t2 repeat ch0=3", 3'b001, 16, vals[3], 1, 3'b001, 1'b0, 1, 3'd3);
    req = 3'b111;
    txn("t3 rr ch1=6", 3'b010, PRIME ? 33 : 16, PRIME ? vals[6] : vals[3], 1,
        3'b111, 1'b0, PRIME ? 2 : 1, 3'd6);
    txn("t4 rr ch2=5", 3'b100, PRIME ? 33 : 16, PRIME ? vals[5] : vals[6], 1,
        3'b111, 1'b0, PRIME ? 2 : 1, 3'd5);
    txn("t5 rr ch0=3 drop", 3'b001, PRIME ? 33 : 16, PRIME ? vals[3] : vals[5], 1,
        3'b000, 1'b1, PRIME ? 2 : 1, 3'd3);
    ch0 = 3'd3; ch1 = 3'd6; ch2 = 3'd5;

    // Abort a frame with reset at frame cycle 8
    req = 3'b010;
    w = 0;
    do begin
      @(posedge adc_clk); #1; w++;
    end while (adc_cs_n !== 1'b0 && w < 20);
    chk("abort grant", 32'(gnt), 32'b010);
    req = 3'b000;
    repeat (8) @(posedge adc_clk);
    #1;
    rst = 1'b1;
    @(posedge adc_clk); #1;
    rst = 1'b0;
    chk("abort cs_n", 32'(adc_cs_n), 32'd1);
    chk("abort gnt", 32'(gnt), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    rv_seen = 0;
    repeat (40) begin
      @(posedge adc_clk); #1;
      if (result_valid !== 3'b000) rv_seen++;
    end
    chk("abort result_valid", 32'(rv_seen), 32'd0);
    chk("abort frames", 32'(frame_q.size()), 32'd0);
    $display("abort: reset at k=8, result_valid pulses=%0d", rv_seen);

    req = 3'b111;
    txn("t6 after abort", 3'b001, PRIME ? 33 : 16, vals[3], 0,
        3'b000, 1'b0, PRIME ? 2 : 1, 3'd3);

    chk("gnt onehot", 32'(onehot_bad), 32'd0);
    chk("din outside addr cycles", 32'(din_bad), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
